dpc_bp_table_merger: RTL

- Sequences (re)loading of the combined bad-pixel table read by the DPC corrector.
- Merges the manual list (host registers) and the auto list (detector output) into one ascending raster-order list with duplicates removed.
- Writes the merged list through the corrector's all_bp write port, publishes the count, and owns bp_table_ready.
- Updates only run while the video stream is idle between frames.

---
 rtl/dpc_bp_table_merger.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dpc_bp_table_merger.sv
// Bad-pixel table merger: rebuilds the corrector's combined table from the
// manual (host) list and the auto (detector) list during a frame gap.
// Output is one ascending, duplicate-free list in {y,x} raster order.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   start, frame_idle            rebuild request, stream-between-frames flag
//   man_num/raddr/rdata          manual list (1-cycle read latency)
//   auto_num/raddr/rdata         auto list (1-cycle read latency)
//   all_bp_wen/waddr/wdata       merged-table write port
//   all_bp_num, bp_table_ready   published count and table-usable flag
//   busy, done                   status; done pulses once per finished merge
//   err_overflow, err_frame      sticky errors, cleared by a start from idle
module dpc_bp_table_merger #(
  parameter int unsigned MAN_NUM    = 256,
  parameter int unsigned MAN_BIT    = 8,
  parameter int unsigned AUTO_NUM   = 256,
  parameter int unsigned AUTO_BIT   = 8,
  parameter int unsigned ALL_BP_NUM = 512,
  parameter int unsigned ALL_BP_BIT = 9
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  frame_idle,
  input  logic [MAN_BIT:0]      man_num,
  output logic [MAN_BIT-1:0]    man_raddr,
  input  logic [31:0]           man_rdata,
  input  logic [AUTO_BIT:0]     auto_num,
  output logic [AUTO_BIT-1:0]   auto_raddr,
  input  logic [31:0]           auto_rdata,
  output logic                  all_bp_wen,
  output logic [ALL_BP_BIT-1:0] all_bp_waddr,
  output logic [31:0]           all_bp_wdata,
  output logic [ALL_BP_BIT:0]   all_bp_num,
  output logic                  bp_table_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_frame
);

  localparam int unsigned MP_W = MAN_BIT + 1;
  localparam int unsigned AP_W = AUTO_BIT + 1;
  localparam int unsigned WC_W = ALL_BP_BIT + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GAP, S_FETCH, S_CMP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [MP_W-1:0]       mp_q, mp_d, man_cnt_q, man_cnt_d;
  logic [AP_W-1:0]       ap_q, ap_d, auto_cnt_q, auto_cnt_d;
  logic [WC_W-1:0]       wc_q, wc_d, num_q, num_d;
  logic                  pending_q, pending_d;
  logic                  wen_q, wen_d;
  logic [ALL_BP_BIT-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic                  ovf_q, ovf_d, frm_q, frm_d;

  // Merge-step datapath: compare keys, pick the entry, advance pointers.
  logic            mv, av, take_m, take_a, remain;
  logic [31:0]     man_key, auto_key;
  logic [MP_W-1:0] mp_n;
  logic [AP_W-1:0] ap_n;
  logic [WC_W-1:0] wc_n;

  assign mv       = mp_q < man_cnt_q;
  assign av       = ap_q < auto_cnt_q;
  assign man_key  = {man_rdata[15:0], man_rdata[31:16]};
  assign auto_key = {auto_rdata[15:0], auto_rdata[31:16]};
  // Equal keys take both entries at once, which drops the duplicate.
  assign take_m   = mv && (!av || (man_key <= auto_key));
  assign take_a   = av && (!mv || (auto_key <= man_key));
  assign mp_n     = mp_q + MP_W'(take_m);
  assign ap_n     = ap_q + AP_W'(take_a);
  assign wc_n     = wc_q + WC_W'(1);
  assign remain   = (mp_n < man_cnt_q) || (ap_n < auto_cnt_q);

  // State and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      mp_q       <= '0;
      ap_q       <= '0;
      wc_q       <= '0;
      man_cnt_q  <= '0;
      auto_cnt_q <= '0;
      num_q      <= '0;
      pending_q  <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mp_q       <= mp_d;
      ap_q       <= ap_d;
      wc_q       <= wc_d;
      man_cnt_q  <= man_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      num_q      <= num_d;
      pending_q  <= pending_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      frm_q      <= frm_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mp_d       = mp_q;
    ap_d       = ap_q;
    wc_d       = wc_q;
    man_cnt_d  = man_cnt_q;
    auto_cnt_d = auto_cnt_q;
    num_d      = num_q;
    pending_d  = pending_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    frm_d      = frm_q;

    // A start during a merge is remembered; DONE consumes its own start.
    if (start && (state_q != S_IDLE) && (state_q != S_DONE)) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_GAP;
          ovf_d   = 1'b0;
          frm_d   = 1'b0;
        end
      end
      S_WAIT_GAP: begin
        if (frame_idle) begin
          state_d    = S_FETCH;
          ready_d    = 1'b0;
          mp_d       = '0;
          ap_d       = '0;
          wc_d       = '0;
          // Counts beyond the list depth are clamped to the depth.
          man_cnt_d  = (man_num > MP_W'(MAN_NUM)) ? MP_W'(MAN_NUM) : man_num;
          auto_cnt_d = (auto_num > AP_W'(AUTO_NUM)) ? AP_W'(AUTO_NUM) : auto_num;
        end
      end
      S_FETCH: begin
        if (!frame_idle) frm_d = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (!frame_idle) frm_d = 1'b1;
        if (!mv && !av) begin
          state_d = S_DONE;
        end else begin
          wen_d   = 1'b1;
          waddr_d = wc_q[ALL_BP_BIT-1:0];
          wdata_d = take_m ? man_rdata : auto_rdata;
          mp_d    = mp_n;
          ap_d    = ap_n;
          wc_d    = wc_n;
          if ((wc_n == WC_W'(ALL_BP_NUM)) && remain) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        num_d     = wc_q;
        ready_d   = 1'b1;
        done_d    = 1'b1;
        pending_d = 1'b0;
        state_d   = (pending_q || start) ? S_WAIT_GAP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  assign man_raddr      = mp_q[MAN_BIT-1:0];
  assign auto_raddr     = ap_q[AUTO_BIT-1:0];
  assign all_bp_wen     = wen_q;
  assign all_bp_waddr   = waddr_q;
  assign all_bp_wdata   = wdata_q;
  assign all_bp_num     = num_q;
  assign bp_table_ready = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_overflow   = ovf_q;
  assign err_frame      = frm_q;

endmodule
